alu_issue_stage: RTL and testbench

- Execute-entry pipeline stage sitting directly upstream of alu; captures decoded ops from decode (ID) and presents a stable operand bundle plus alu_op to the ALU.
- Provides a 2-entry skid buffer (valid/ready on both sides) and operand forwarding from the EX and WB result buses.
- Tracks RAW dependencies on entries it still holds, and withholds issue until every operand is resolved.

---
 rtl/alu_issue_pkg.sv | 59 +++++
 rtl/core.sv | 17 +
 rtl/alu_issue_entry.sv | 51 +++++
 rtl/alu_issue_stage.sv | 156 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Types, widths and the operand-forwarding priority rule shared by the ALU issue stage.
package alu_issue_pkg;

  localparam int unsigned ISSUE_DATA_W  = 32;
  localparam int unsigned ISSUE_NUM_OPS = 2;
  localparam int unsigned ISSUE_ADDR_W  = 5;

  localparam logic [ISSUE_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } issue_state_e;

  // rs is kept so a pending operand can later match its producer on a result bus
  typedef struct packed {
    core::alu_operation_t                             alu_op;
    logic [ISSUE_ADDR_W-1:0]                          rd;
    logic [ISSUE_NUM_OPS-1:0][ISSUE_ADDR_W-1:0]       rs;
    logic [ISSUE_NUM_OPS-1:0][ISSUE_DATA_W-1:0]       operands;
    logic [ISSUE_NUM_OPS-1:0]                         pending;
  } issue_entry_t;

  typedef struct packed {
    logic                    pending;
    logic [ISSUE_DATA_W-1:0] data;
  } operand_res_t;

  // Capture-time source select: older in-stage producer, then EX, then WB, then register file
  function automatic operand_res_t resolve_operand(
    input logic [ISSUE_ADDR_W-1:0] rs,
    input logic [ISSUE_DATA_W-1:0] rf_data,
    input logic                    older_valid,
    input logic [ISSUE_ADDR_W-1:0] older_rd,
    input logic                    ex_valid,
    input logic [ISSUE_ADDR_W-1:0] ex_rd,
    input logic [ISSUE_DATA_W-1:0] ex_data,
    input logic                    wb_valid,
    input logic [ISSUE_ADDR_W-1:0] wb_rd,
    input logic [ISSUE_DATA_W-1:0] wb_data
  );
    operand_res_t res;
    res.pending = 1'b0;
    res.data    = rf_data;
    if (rs == REG_ZERO) begin
      res.data = '0;
    end else if (older_valid && (older_rd != REG_ZERO) && (older_rd == rs)) begin
      res.pending = 1'b1;
      res.data    = '0;
    end else if (ex_valid && (ex_rd == rs)) begin
      res.data = ex_data;
    end else if (wb_valid && (wb_rd == rs)) begin
      res.data = wb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/core.sv
// Core-wide shared types; the ALU operation encoding used by decode, issue and alu.
package core;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } alu_operation_t;

endpackage

// File: rtl/alu_issue_entry.sv
// One issue buffer slot; pending operands snoop the EX/WB result buses every cycle.
module alu_issue_entry
  import alu_issue_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    resolve_load_i,
  input  issue_entry_t            load_entry_i,
  input  logic                    fwd_ex_valid_i,
  input  logic [ISSUE_ADDR_W-1:0] fwd_ex_rd_i,
  input  logic [ISSUE_DATA_W-1:0] fwd_ex_data_i,
  input  logic                    fwd_wb_valid_i,
  input  logic [ISSUE_ADDR_W-1:0] fwd_wb_rd_i,
  input  logic [ISSUE_DATA_W-1:0] fwd_wb_data_i,
  output issue_entry_t            entry_o
);

  issue_entry_t entry_q;
  issue_entry_t entry_d;

  // Fresh captures skip snooping: their pending producer has not reached a bus yet
  always_comb begin
    entry_d = load_i ? load_entry_i : entry_q;
    if (!load_i || resolve_load_i) begin
      for (int unsigned i = 0; i < ISSUE_NUM_OPS; i++) begin
        if (entry_d.pending[i]) begin
          if (fwd_ex_valid_i && (fwd_ex_rd_i != REG_ZERO) && (fwd_ex_rd_i == entry_d.rs[i])) begin
            entry_d.operands[i] = fwd_ex_data_i;
            entry_d.pending[i]  = 1'b0;
          end else if (fwd_wb_valid_i && (fwd_wb_rd_i != REG_ZERO) &&
                       (fwd_wb_rd_i == entry_d.rs[i])) begin
            entry_d.operands[i] = fwd_wb_data_i;
            entry_d.pending[i]  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-entry stage: 2-entry skid buffer with EX/WB forwarding and RAW tracking ahead of alu.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = ISSUE_DATA_W,
  parameter int unsigned NUM_OPERANDS   = ISSUE_NUM_OPS,
  parameter int unsigned REG_ADDR_WIDTH = ISSUE_ADDR_W
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic                                         id_valid_i,
  output logic                                         id_ready_o,
  input  core::alu_operation_t                         id_alu_op_i,
  input  logic [NUM_OPERANDS-1:0][REG_ADDR_WIDTH-1:0]  id_rs_addr_i,
  input  logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]      id_rs_data_i,
  input  logic [DATA_WIDTH-1:0]                        id_imm_i,
  input  logic                                         id_imm_sel_i,
  input  logic [REG_ADDR_WIDTH-1:0]                    id_rd_addr_i,
  input  logic                                         fwd_ex_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]                    fwd_ex_rd_i,
  input  logic [DATA_WIDTH-1:0]                        fwd_ex_data_i,
  input  logic                                         fwd_wb_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]                    fwd_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]                        fwd_wb_data_i,
  output logic                                         ex_valid_o,
  input  logic                                         ex_ready_i,
  output logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]      ex_operands_o,
  output core::alu_operation_t                         ex_alu_op_o,
  output logic [REG_ADDR_WIDTH-1:0]                    ex_rd_addr_o
);

  issue_state_e state_q;
  issue_state_e state_d;

  issue_entry_t main_entry;
  issue_entry_t skid_entry;
  issue_entry_t cap_entry;
  issue_entry_t main_load_entry;

  logic main_valid;
  logic accept;
  logic fire;
  logic main_load;
  logic main_from_skid;
  logic skid_load;

  assign main_valid = (state_q != ST_EMPTY);
  assign id_ready_o = (state_q != ST_SKID);
  assign ex_valid_o = main_valid & ~(|main_entry.pending);
  assign accept     = id_valid_i & id_ready_o;
  assign fire       = ex_valid_o & ex_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_FULL;
          main_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (fire && accept) begin
          main_load = 1'b1;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d   = ST_SKID;
          skid_load = 1'b1;
        end
      end
      ST_SKID: begin
        if (fire) begin
          state_d        = ST_FULL;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
  end

  // The older op for any capture is whatever currently sits in main (departing or stalled)
  always_comb begin
    operand_res_t res;
    res              = '0;
    cap_entry        = '0;
    cap_entry.alu_op = id_alu_op_i;
    cap_entry.rd     = id_rd_addr_i;
    cap_entry.rs     = id_rs_addr_i;
    for (int unsigned i = 0; i < ISSUE_NUM_OPS; i++) begin
      if ((i == 1) && id_imm_sel_i) begin
        cap_entry.operands[i] = id_imm_i;
        cap_entry.pending[i]  = 1'b0;
      end else begin
        res = resolve_operand(id_rs_addr_i[i], id_rs_data_i[i], main_valid, main_entry.rd,
                              fwd_ex_valid_i, fwd_ex_rd_i, fwd_ex_data_i,
                              fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i);
        cap_entry.operands[i] = res.data;
        cap_entry.pending[i]  = res.pending;
      end
    end
  end

  assign main_load_entry = main_from_skid ? skid_entry : cap_entry;

  alu_issue_entry u_main (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_i         (main_load),
    .resolve_load_i (main_from_skid),
    .load_entry_i   (main_load_entry),
    .fwd_ex_valid_i (fwd_ex_valid_i),
    .fwd_ex_rd_i    (fwd_ex_rd_i),
    .fwd_ex_data_i  (fwd_ex_data_i),
    .fwd_wb_valid_i (fwd_wb_valid_i),
    .fwd_wb_rd_i    (fwd_wb_rd_i),
    .fwd_wb_data_i  (fwd_wb_data_i),
    .entry_o        (main_entry)
  );

  alu_issue_entry u_skid (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_i         (skid_load),
    .resolve_load_i (1'b0),
    .load_entry_i   (cap_entry),
    .fwd_ex_valid_i (fwd_ex_valid_i),
    .fwd_ex_rd_i    (fwd_ex_rd_i),
    .fwd_ex_data_i  (fwd_ex_data_i),
    .fwd_wb_valid_i (fwd_wb_valid_i),
    .fwd_wb_rd_i    (fwd_wb_rd_i),
    .fwd_wb_data_i  (fwd_wb_data_i),
    .entry_o        (skid_entry)
  );

  assign ex_operands_o = main_entry.operands;
  assign ex_alu_op_o   = main_entry.alu_op;
  assign ex_rd_addr_o  = main_entry.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: capture vector table plus skid/dependency/flush sequences.
module tb_alu_issue_stage;
  import core::*;

  logic                 clk = 1'b0;
  logic                 rst, flush, id_valid, id_ready, id_imm_sel;
  logic                 fwd_ex_valid, fwd_wb_valid, ex_valid, ex_ready;
  alu_operation_t       id_alu_op, ex_alu_op;
  logic [1:0][4:0]      id_rs_addr;
  logic [1:0][31:0]     id_rs_data, ex_operands;
  logic [31:0]          id_imm, fwd_ex_data, fwd_wb_data;
  logic [4:0]           id_rd, fwd_ex_rd, fwd_wb_rd, ex_rd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    alu_operation_t op;
    logic [4:0]     rd, rs0, rs1;
    logic [31:0]    rf0, rf1;
    logic           imm_sel;
    logic [31:0]    imm;
    logic           exv;
    logic [4:0]     exrd;
    logic [31:0]    exd;
    logic           wbv;
    logic [4:0]     wbrd;
    logic [31:0]    wbd;
    logic [31:0]    e0, e1;
  } vec_t;

  vec_t vecs[7];

  alu_issue_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .id_valid_i     (id_valid),
    .id_ready_o     (id_ready),
    .id_alu_op_i    (id_alu_op),
    .id_rs_addr_i   (id_rs_addr),
    .id_rs_data_i   (id_rs_data),
    .id_imm_i       (id_imm),
    .id_imm_sel_i   (id_imm_sel),
    .id_rd_addr_i   (id_rd),
    .fwd_ex_valid_i (fwd_ex_valid),
    .fwd_ex_rd_i    (fwd_ex_rd),
    .fwd_ex_data_i  (fwd_ex_data),
    .fwd_wb_valid_i (fwd_wb_valid),
    .fwd_wb_rd_i    (fwd_wb_rd),
    .fwd_wb_data_i  (fwd_wb_data),
    .ex_valid_o     (ex_valid),
    .ex_ready_i     (ex_ready),
    .ex_operands_o  (ex_operands),
    .ex_alu_op_o    (ex_alu_op),
    .ex_rd_addr_o   (ex_rd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string name, input alu_operation_t op, input logic [4:0] rd,
                            input logic [31:0] e0, input logic [31:0] e1);
    chk({name, ".valid"}, 32'(ex_valid), 32'd1);
    chk({name, ".op0"}, ex_operands[0], e0);
    chk({name, ".op1"}, ex_operands[1], e1);
    chk({name, ".alu_op"}, 32'(ex_alu_op), 32'(op));
    chk({name, ".rd"}, 32'(ex_rd), 32'(rd));
  endtask

  task automatic offer(input alu_operation_t op, input logic [4:0] rd, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [31:0] d0, input logic [31:0] d1);
    id_valid      = 1'b1;
    id_alu_op     = op;
    id_rd         = rd;
    id_rs_addr[0] = rs0;
    id_rs_addr[1] = rs1;
    id_rs_data[0] = d0;
    id_rs_data[1] = d1;
    id_imm_sel    = 1'b0;
    id_imm        = '0;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_imm_sel   = 1'b0;
    fwd_ex_valid = 1'b0;
    fwd_ex_rd    = '0;
    fwd_ex_data  = '0;
    fwd_wb_valid = 1'b0;
    fwd_wb_rd    = '0;
    fwd_wb_data  = '0;
  endtask

  initial begin
    //            op   rd rs0 rs1 rf0       rf1       isel imm        exv exrd exd       wbv wbrd wbd       e0        e1
    vecs[0] = '{ADD,  7, 1,  2, 32'd5,    32'd7,    0,   32'h0,     0,  0,   32'h0,    0,  0,   32'h0,    32'd5,    32'd7};
    vecs[1] = '{SUB,  8, 3,  0, 32'd11,   32'd22,   0,   32'h0,     1,  3,   32'hAA,   1,  3,   32'hBB,   32'hAA,   32'h0};
    vecs[2] = '{XOR,  9, 3,  4, 32'h33,   32'h44,   0,   32'h0,     0,  3,   32'hAA,   1,  3,   32'hBB,   32'hBB,   32'h44};
    vecs[3] = '{OR,   1, 0,  0, 32'h55,   32'h66,   0,   32'h0,     1,  0,   32'hCC,   1,  0,   32'hDD,   32'h0,    32'h0};
    vecs[4] = '{AND,  2, 5,  6, 32'h50,   32'h60,   1,   32'hFFF,   1,  6,   32'hEE,   0,  0,   32'h0,    32'h50,   32'hFFF};
    vecs[5] = '{SLT,  3, 6,  5, 32'h1,    32'h2,    0,   32'h0,     1,  5,   32'h11,   1,  6,   32'h22,   32'h22,   32'h11};
    vecs[6] = '{SRA, 31, 7,  8, 32'h70,   32'h80,   0,   32'h0,     1,  9,   32'h99,   1,  8,   32'h88,   32'h70,   32'h88};

    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_alu_op = ADD; id_rd = '0; id_rs_addr = '0; id_rs_data = '0; id_imm = '0;
    idle();
    step(); step();
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.id_ready", 32'(id_ready), 32'd1);
    chk("rst.op0", ex_operands[0], 32'd0);
    chk("rst.op1", ex_operands[1], 32'd0);
    chk("rst.alu_op", 32'(ex_alu_op), 32'(ADD));
    chk("rst.rd", 32'(ex_rd), 32'd0);
    rst = 1'b0;
    step();

    // capture table: each op accepted from empty, checked the next cycle, then fired
    for (int k = 0; k < 7; k++) begin
      offer(vecs[k].op, vecs[k].rd, vecs[k].rs0, vecs[k].rs1, vecs[k].rf0, vecs[k].rf1);
      id_imm_sel   = vecs[k].imm_sel;
      id_imm       = vecs[k].imm;
      fwd_ex_valid = vecs[k].exv;
      fwd_ex_rd    = vecs[k].exrd;
      fwd_ex_data  = vecs[k].exd;
      fwd_wb_valid = vecs[k].wbv;
      fwd_wb_rd    = vecs[k].wbrd;
      fwd_wb_data  = vecs[k].wbd;
      step();
      idle();
      chk_bundle($sformatf("vec%0d", k), vecs[k].op, vecs[k].rd, vecs[k].e0, vecs[k].e1);
      step();
    end
    chk("vec.drained", 32'(ex_valid), 32'd0);

    // backpressure: two accepted, third held at ID, then issued in order
    ex_ready = 1'b0;
    offer(ADD, 10, 1, 2, 32'hA1, 32'hA2);
    step();
    chk("bp.ready1", 32'(id_ready), 32'd1);
    offer(SUB, 11, 3, 5, 32'hB1, 32'hB2);
    step();
    chk("bp.ready2", 32'(id_ready), 32'd0);
    offer(XOR, 13, 6, 7, 32'hC1, 32'hC2);
    step();
    chk("bp.ready3", 32'(id_ready), 32'd0);
    chk_bundle("bp.op1", ADD, 10, 32'hA1, 32'hA2);
    ex_ready = 1'b1;
    step();
    chk("bp.ready4", 32'(id_ready), 32'd1);
    chk_bundle("bp.op2", SUB, 11, 32'hB1, 32'hB2);
    step();
    idle();
    chk_bundle("bp.op3", XOR, 13, 32'hC1, 32'hC2);
    step();
    chk("bp.drained", 32'(ex_valid), 32'd0);

    // dependent op: B waits in skid on A's rd, then resolves from EX over WB
    ex_ready = 1'b0;
    offer(ADD, 4, 1, 2, 32'h10, 32'h20);
    step();
    offer(SUB, 12, 4, 2, 32'h999, 32'h77);
    step();
    idle();
    chk_bundle("dep.a", ADD, 4, 32'h10, 32'h20);
    ex_ready = 1'b1;
    step();
    chk("dep.b_wait1", 32'(ex_valid), 32'd0);
    chk("dep.b_rd", 32'(ex_rd), 32'd12);
    step();
    chk("dep.b_wait2", 32'(ex_valid), 32'd0);
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd4; fwd_ex_data = 32'h1234;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h5555;
    step();
    idle();
    chk_bundle("dep.b", SUB, 12, 32'h1234, 32'h77);
    step();
    chk("dep.drained", 32'(ex_valid), 32'd0);

    // flush from SKID with an op offered
    ex_ready = 1'b0;
    offer(ADD, 1, 1, 2, 32'h1, 32'h2);
    step();
    offer(ADD, 2, 3, 5, 32'h3, 32'h4);
    step();
    offer(OR, 3, 6, 7, 32'h5, 32'h6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("fl_skid.valid", 32'(ex_valid), 32'd0);
    chk("fl_skid.id_ready", 32'(id_ready), 32'd1);
    step();
    chk("fl_skid.dropped", 32'(ex_valid), 32'd0);

    // flush from FULL with a same-cycle accept
    offer(AND, 5, 1, 2, 32'h1, 32'h2);
    step();
    offer(OR, 6, 3, 5, 32'h3, 32'h4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("fl_full.valid", 32'(ex_valid), 32'd0);
    chk("fl_full.id_ready", 32'(id_ready), 32'd1);
    step();
    chk("fl_full.dropped", 32'(ex_valid), 32'd0);

    // immediate on operand 1 ignores the RAW match on rs2
    offer(ADD, 9, 1, 2, 32'h1, 32'h2);
    step();
    offer(SLL, 14, 1, 9, 32'h21, 32'h5A5A);
    id_imm_sel = 1'b1;
    id_imm     = 32'hFFF;
    step();
    idle();
    ex_ready = 1'b1;
    step();
    chk_bundle("imm", SLL, 14, 32'h21, 32'hFFF);
    step();
    chk("imm.drained", 32'(ex_valid), 32'd0);

    // reset dominates flush and a concurrent accept
    ex_ready = 1'b0;
    offer(SUB, 17, 1, 2, 32'hDEAD, 32'hBEEF);
    step();
    chk_bundle("rd.pre", SUB, 17, 32'hDEAD, 32'hBEEF);
    rst   = 1'b1;
    flush = 1'b1;
    offer(XOR, 18, 3, 5, 32'h7, 32'h8);
    step();
    chk("rd.valid", 32'(ex_valid), 32'd0);
    chk("rd.id_ready", 32'(id_ready), 32'd1);
    chk("rd.op0", ex_operands[0], 32'd0);
    chk("rd.op1", ex_operands[1], 32'd0);
    chk("rd.alu_op", 32'(ex_alu_op), 32'(ADD));
    chk("rd.rd", 32'(ex_rd), 32'd0);
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    step();
    chk("rd.after", 32'(ex_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
